// File: rtl/reg_write_arb.sv
// ----------------------------------------------------------------------------
// reg_write_arb
//
// Round-robin arbiter that lets N requesters take turns writing a single
// shared WIDTH-bit register. Each granted write occupies three cycles:
// IDLE (arbitrate) -> WRITE (capture data) -> RELEASE (drop grant/ack).
//
// Ports
//   clk    in   1        clock, all state updates on rising edge
//   rst    in   1        asynchronous active-low reset
//   req    in   N        per-requester write request (level)
//   din    in   N*WIDTH  requester data, slice i = din[i*WIDTH +: WIDTH]
//   clr    in   1        synchronous clear of q, honoured only in IDLE
//   gnt    out  N        registered one-hot grant
//   ack    out  N        registered one-hot completion pulse (RELEASE cycle)
//   q      out  WIDTH    shared register contents
//   owner  out  2        index of the requester that last wrote q
//   busy   out  1        high whenever the FSM is not in IDLE
//
// Only N = 4 is supported (owner and the round-robin pointer are 2 bits).
// ----------------------------------------------------------------------------
module reg_write_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] din,
    input  logic               clr,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic [1:0]         owner,
    output logic               busy
);

    localparam int unsigned IW = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StRelease = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_d;

    logic [N-1:0]      r_gnt;
    logic [N-1:0]      r_ack;
    logic [WIDTH-1:0]  r_q;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_ptr;

    logic [N-1:0]      w_gnt_d;
    logic [N-1:0]      w_ack_d;
    logic [WIDTH-1:0]  w_q_d;
    logic [IW-1:0]     w_owner_d;
    logic [IW-1:0]     w_ptr_d;

    logic [IW-1:0]     w_cand;
    logic [IW-1:0]     w_win_idx;
    logic [N-1:0]      w_win_onehot;
    logic [WIDTH-1:0]  w_sel_data;

    // Round-robin search starting at ptr+1. Walking k from N down to 1 and
    // overwriting on every hit leaves the nearest asserted index (smallest k)
    // as the winner; k = N wraps back to ptr itself.
    always_comb begin
        w_win_idx = r_ptr;
        w_cand    = r_ptr;
        for (int k = int'(N); k >= 1; k--) begin
            w_cand = r_ptr + IW'(k);
            if (req[w_cand]) begin
                w_win_idx = w_cand;
            end
        end
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
    end

    // The pointer holds the granted index throughout WRITE, so it doubles as
    // the data-select for the capture.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_ptr == IW'(i)) begin
                w_sel_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (!clr && (|req)) begin
                    w_state_d = StWrite;
                end
            end
            StWrite:   w_state_d = StRelease;
            StRelease: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Output / datapath next values; everything holds unless the state says
    // otherwise, which covers the idle-with-no-request case.
    always_comb begin
        w_gnt_d   = r_gnt;
        w_ack_d   = r_ack;
        w_q_d     = r_q;
        w_owner_d = r_owner;
        w_ptr_d   = r_ptr;
        case (r_state)
            StIdle: begin
                if (clr) begin
                    w_q_d = '0;
                end else if (|req) begin
                    w_gnt_d = w_win_onehot;
                    w_ptr_d = w_win_idx;
                end
            end
            StWrite: begin
                w_q_d     = w_sel_data;
                w_owner_d = r_ptr;
                w_ack_d   = r_gnt;
            end
            StRelease: begin
                w_gnt_d = '0;
                w_ack_d = '0;
            end
            default: begin
                w_gnt_d = '0;
                w_ack_d = '0;
            end
        endcase
    end

    // Pointer resets to N-1 so the first arbitration favours requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_ptr   <= IW'(N - 1);
        end else begin
            r_gnt   <= w_gnt_d;
            r_ack   <= w_ack_d;
            r_q     <= w_q_d;
            r_owner <= w_owner_d;
            r_ptr   <= w_ptr_d;
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_reg_write_arb.sv
// ----------------------------------------------------------------------------
// tb_reg_write_arb
//
// Directed bench for reg_write_arb. A vector table walks the FSM through
// single writes, clear in IDLE, wrap-around arbitration and a dropped request;
// hand-written sequences cover asynchronous reset mid-transfer and a held
// all-request round-robin run.
// ----------------------------------------------------------------------------
module tb_reg_write_arb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] din;
    logic               clr;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   q;
    logic [1:0]         owner;
    logic               busy;

    int n_checks;
    int n_errors;

    reg_write_arb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .clr   (clr),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic        clr;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    localparam logic [31:0] D0 = 32'h4433_22A5;
    localparam logic [31:0] D1 = 32'h4433_2211;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                           input logic [7:0] e_q, input logic [1:0] e_owner, input logic e_busy);
        chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({tag, ".ack"},   32'(ack),   32'(e_ack));
        chk({tag, ".q"},     32'(q),     32'(e_q));
        chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    endtask

    initial begin
        logic [3:0] e_oh;
        logic [7:0] e_q;

        n_checks = 0;
        n_errors = 0;

        //               req      din clr  gnt      ack      q      own  busy
        vecs[0]  = '{4'b0001, D0, 1'b0, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1};
        vecs[1]  = '{4'b0000, D0, 1'b0, 4'b0001, 4'b0001, 8'hA5, 2'd0, 1'b1};
        vecs[2]  = '{4'b0000, D0, 1'b0, 4'b0000, 4'b0000, 8'hA5, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, D0, 1'b0, 4'b0000, 4'b0000, 8'hA5, 2'd0, 1'b0};
        // clear beats a simultaneous request in IDLE
        vecs[4]  = '{4'b0010, D1, 1'b1, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
        vecs[5]  = '{4'b0010, D1, 1'b0, 4'b0010, 4'b0000, 8'h00, 2'd0, 1'b1};
        vecs[6]  = '{4'b0000, D1, 1'b0, 4'b0010, 4'b0010, 8'h22, 2'd1, 1'b1};
        vecs[7]  = '{4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 8'h22, 2'd1, 1'b0};
        // pointer=1, req=1001: requester 3 wins before 0; clr ignored in WRITE
        vecs[8]  = '{4'b1001, D1, 1'b0, 4'b1000, 4'b0000, 8'h22, 2'd1, 1'b1};
        vecs[9]  = '{4'b1001, D1, 1'b1, 4'b1000, 4'b1000, 8'h44, 2'd3, 1'b1};
        vecs[10] = '{4'b1001, D1, 1'b0, 4'b0000, 4'b0000, 8'h44, 2'd3, 1'b0};
        vecs[11] = '{4'b1001, D1, 1'b0, 4'b0001, 4'b0000, 8'h44, 2'd3, 1'b1};
        vecs[12] = '{4'b0000, D1, 1'b0, 4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1};
        vecs[13] = '{4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b0};
        // request dropped during WRITE still completes
        vecs[14] = '{4'b0100, D1, 1'b0, 4'b0100, 4'b0000, 8'h11, 2'd0, 1'b1};
        vecs[15] = '{4'b0000, D1, 1'b0, 4'b0100, 4'b0100, 8'h33, 2'd2, 1'b1};
        vecs[16] = '{4'b0000, D1, 1'b0, 4'b0000, 4'b0000, 8'h33, 2'd2, 1'b0};

        // Reset takes effect without a clock edge.
        rst = 1'b0;
        req = '0;
        din = D0;
        clr = 1'b0;
        #1;
        chk_all("reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            req = vecs[i].req;
            din = vecs[i].din;
            clr = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q,
                    vecs[i].owner, vecs[i].busy);
        end

        // Asynchronous reset mid-WRITE (pointer is 2, requester 3 wins).
        req = 4'b1000;
        clr = 1'b0;
        tick();
        chk_all("rst_pre", 4'b1000, 4'b0000, 8'h33, 2'd2, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst_mid", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk_all($sformatf("rst_post%0d", t), 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        end

        // All requests held: grants rotate 0,1,2,3,0, one write per 3 cycles.
        req = 4'b1111;
        din = D1;
        e_q = 8'h00;
        for (int t = 0; t < 15; t++) begin
            int j;
            j = (t / 3) % 4;
            e_oh = 4'b0001 << j;
            tick();
            case (t % 3)
                0: chk_all($sformatf("rr%0d_gnt", t), e_oh, 4'b0000, e_q,
                           (t == 0) ? 2'd0 : 2'(((t / 3) + 3) % 4), 1'b1);
                1: begin
                    e_q = 8'(8'h11 * (j + 1));
                    chk_all($sformatf("rr%0d_wr", t), e_oh, e_oh, e_q, 2'(j), 1'b1);
                end
                default: chk_all($sformatf("rr%0d_rel", t), 4'b0000, 4'b0000, e_q, 2'(j), 1'b0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
